// File: rtl/adc_trigger_capture.sv
// Rising-threshold trigger on the live ADC sample. On a crossing it freezes the
// pre-trigger delay vector and streams it as one header + DEPTH sample packet.
module adc_trigger_capture #(
  parameter int DATA_W    = 14,
  parameter int DEPTH     = 100,
  parameter int THRESHOLD = 9000,
  parameter int HOLDOFF   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       ADC_IN,
  input  logic [DEPTH*DATA_W-1:0] DelayVec,
  input  logic                    arm,
  input  logic                    out_ready,
  output logic [15:0]             out_data,
  output logic                    out_valid,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic                    busy,
  output logic [15:0]             trig_count,
  output logic [7:0]              missed_count
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HOLD_W = $clog2(HOLDOFF + 1);

  localparam logic [DATA_W-1:0] THRESH    = DATA_W'(THRESHOLD);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_STREAM,
    S_HOLDOFF
  } state_t;

  state_t                  state_q,     state_d;
  logic [DATA_W-1:0]       prev_q;
  logic [DEPTH*DATA_W-1:0] snap_q,      snap_d;
  logic [IDX_W-1:0]        idx_q,       idx_d;
  logic [HOLD_W-1:0]       hold_q,      hold_d;
  logic [15:0]             data_q,      data_d;
  logic                    valid_q,     valid_d;
  logic                    sop_q,       sop_d;
  logic                    eop_q,       eop_d;
  logic                    busy_q,      busy_d;
  logic [15:0]             trig_q,      trig_d;
  logic [7:0]              missed_q,    missed_d;

  logic                    crossing;
  logic                    xfer;
  logic [IDX_W-1:0]        word_idx;
  logic [DATA_W-1:0]       sample;

  assign crossing = (ADC_IN >= THRESH) && (prev_q < THRESH);
  assign xfer     = valid_q && out_ready;

  // After the header the first sample shown is idx_q itself; later beats step down.
  assign word_idx = sop_q ? idx_q : (idx_q - IDX_W'(1));
  assign sample   = snap_q[word_idx*DATA_W +: DATA_W];

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    data_d   = data_q;
    valid_d  = valid_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    trig_d   = trig_q;
    missed_d = missed_q;

    if (crossing && (state_q == S_STREAM || state_q == S_HOLDOFF) && missed_q != 8'hFF) begin
      missed_d = missed_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!arm) begin
          state_d = S_IDLE;
        end else if (crossing) begin
          snap_d  = DelayVec;
          trig_d  = trig_q + 16'd1;
          data_d  = {2'b10, trig_q[13:0]};
          valid_d = 1'b1;
          sop_d   = 1'b1;
          eop_d   = 1'b0;
          idx_d   = LAST_IDX;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          if (eop_q) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            data_d  = '0;
            hold_d  = HOLD_LOAD;
            state_d = S_HOLDOFF;
          end else begin
            idx_d  = word_idx;
            sop_d  = 1'b0;
            data_d = 16'(sample);
            eop_d  = (word_idx == '0);
          end
        end
      end
      S_HOLDOFF: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q <= HOLD_W'(1)) begin
          hold_d  = '0;
          state_d = arm ? S_ARMED : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d == S_STREAM) || (state_d == S_HOLDOFF);

  // NOTE: the snapshot is a wide register, not RAM, so clearing it on reset is cheap and intended.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      prev_q   <= '0;
      snap_q   <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      busy_q   <= 1'b0;
      trig_q   <= '0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= ADC_IN;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      busy_q   <= busy_d;
      trig_q   <= trig_d;
      missed_q <= missed_d;
    end
  end

  assign out_data     = data_q;
  assign out_valid    = valid_q;
  assign out_sop      = sop_q;
  assign out_eop      = eop_q;
  assign busy         = busy_q;
  assign trig_count   = trig_q;
  assign missed_count = missed_q;

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Scoreboard bench for adc_trigger_capture: stimulus pushes expected packet words,
// a negedge monitor pops and compares every transferred word.
module tb_adc_trigger_capture;

  localparam int DATA_W    = 14;
  localparam int DEPTH     = 100;
  localparam int THRESHOLD = 9000;
  localparam int HOLDOFF   = 16;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [15:0] data;
  } word_t;

  logic                    clk   = 1'b0;
  logic                    reset = 1'b1;
  logic [DATA_W-1:0]       adc   = '0;
  logic [DEPTH*DATA_W-1:0] dvec  = '0;
  logic                    arm   = 1'b0;
  logic                    ready = 1'b1;
  logic [15:0]             out_data;
  logic                    out_valid, out_sop, out_eop, busy;
  logic [15:0]             trig_count;
  logic [7:0]              missed_count;

  logic [DATA_W-1:0] dl [DEPTH];
  word_t             exp_q[$];
  word_t             mon_e;
  word_t             held;
  logic              stall_q = 1'b0;

  int errors = 0;
  int checks = 0;
  int bcnt = 0;
  int cyc = 0;
  int exp_trig = 0;
  int exp_missed = 0;
  int busy_cnt = 0;
  bit bp_mode = 1'b0;

  always #5 clk = ~clk;

  adc_trigger_capture #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .THRESHOLD(THRESHOLD), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ADC_IN       (adc),
    .DelayVec     (dvec),
    .arm          (arm),
    .out_ready    (ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .busy         (busy),
    .trig_count   (trig_count),
    .missed_count (missed_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Baseline noise in 8054..8079, well below the trigger level.
  function automatic logic [DATA_W-1:0] base();
    logic [DATA_W-1:0] v;
    v = DATA_W'(8054 + (bcnt * 7) % 26);
    bcnt++;
    return v;
  endfunction

  // One sample clock: the bench's own delay line shifts in the previous ADC value.
  task automatic tick(input logic [DATA_W-1:0] v);
    @(posedge clk);
    #1;
    for (int i = DEPTH - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = adc;
    adc   = v;
    for (int i = 0; i < DEPTH; i++) dvec[i*DATA_W +: DATA_W] = dl[i];
    cyc++;
    ready = bp_mode ? ((cyc % 4 == 0) || (cyc % 4 == 1)) : 1'b1;
  endtask

  // Called right after the tick that drives the crossing sample: dl is what the DUT snapshots.
  task automatic push_packet();
    exp_q.push_back({1'b1, 1'b0, 2'b10, 14'(exp_trig)});
    for (int i = DEPTH - 1; i >= 0; i--) exp_q.push_back({1'b0, (i == 0), 2'b00, dl[i]});
    exp_trig++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick(base());
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  // Asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check({tag, "_flags"}, {out_data, out_valid, out_sop, out_eop, busy}, 0);
    check({tag, "_counts"}, {trig_count, missed_count}, 0);
    exp_q.delete();
    exp_trig   = 0;
    exp_missed = 0;
    repeat (2) tick(base());
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (stall_q) check("stall_hold", {out_valid, out_sop, out_eop, out_data}, {1'b1, held});
      if (out_valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("stream_word", {out_sop, out_eop, out_data}, mon_e);
        end
      end
      stall_q = out_valid && !ready;
      held    = {out_sop, out_eop, out_data};
    end else begin
      stall_q = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) dl[i] = '0;
    #1;
    check("reset_flags", {out_data, out_valid, out_sop, out_eop, busy}, 0);
    check("reset_counts", {trig_count, missed_count}, 0);
    #10;
    reset = 1'b0;
    repeat (20) tick(base());
    check("idle_no_valid", out_valid, 0);

    // Single event, full throughput.
    arm = 1'b1;
    repeat (110) tick(base());
    tick(14'd8067);
    tick(14'd11054);
    push_packet();
    tick(14'd11054);
    if (busy) busy_cnt++;
    check("hdr_latency", {out_valid, out_sop, out_data}, {1'b1, 1'b1, 16'h8000});
    repeat (199) begin
      tick(14'd11054);
      if (busy) busy_cnt++;
    end
    check("busy_cycles", busy_cnt, DEPTH + 1 + HOLDOFF);
    check("pkt1_drained", exp_q.size(), 0);
    check("trig_count_1", trig_count, 16'(exp_trig));

    // Backpressure 1,1,0,0 repeating.
    bp_mode = 1'b1;
    repeat (3) tick(base());
    tick(14'd11054);
    push_packet();
    tick(base());
    wait_idle("bp_done", 600);
    bp_mode = 1'b0;
    check("trig_count_2", trig_count, 16'(exp_trig));

    // Arming while already above threshold must not trigger.
    arm = 1'b0;
    repeat (3) tick(base());
    repeat (5) tick(14'd13843);
    arm = 1'b1;
    repeat (30) tick(14'd13843);
    check("armed_high_no_pkt", {out_valid, busy}, 0);
    check("armed_high_trig", trig_count, 16'(exp_trig));
    tick(14'd8050);
    tick(14'd11721);
    push_packet();
    tick(base());
    wait_idle("rearm_done", 400);
    check("rearm_trig", trig_count, 16'(exp_trig));
    check("idle_cross_not_missed", missed_count, 8'(exp_missed));

    // Clean start, then a second pulse at beat ~30 of the packet.
    async_reset("rst_clean");
    repeat (3) tick(base());
    tick(14'd11054);
    push_packet();
    repeat (30) tick(base());
    check("in_stream", {out_valid, busy}, 2'b11);
    tick(14'd12000);
    exp_missed++;
    tick(base());
    wait_idle("miss_done", 400);
    check("missed_count_1", missed_count, 8'(exp_missed));
    check("missed_no_extra_trig", trig_count, 16'(exp_trig));
    tick(14'd11054);
    push_packet();
    tick(base());
    wait_idle("after_miss_done", 400);
    check("trig_after_miss", trig_count, 16'(exp_trig));

    // Reset mid-stream at beat ~40.
    tick(14'd11054);
    push_packet();
    repeat (40) tick(base());
    check("pre_reset_streaming", out_valid, 1);
    async_reset("rst_mid");
    repeat (3) tick(base());
    tick(14'd11054);
    push_packet();
    tick(base());
    wait_idle("post_reset_done", 400);
    check("trig_after_reset", trig_count, 16'(exp_trig));
    check("missed_after_reset", missed_count, 8'(exp_missed));

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
